// File: rtl/usb_cmd_parser.sv
// Frame parser for [SYNC, CMD, DATA, CHK] command frames from the USB byte receiver.
// Holds the sig_gen waveform configuration and counts rejected/stalled frames.
module usb_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000,
  parameter int         TO_W      = 16,
  parameter logic [4:0] RST_MODE  = 5'd0,
  parameter logic [7:0] RST_FREQ  = 8'd1,
  parameter logic [7:0] RST_AMP   = 8'd255,
  parameter logic [7:0] RST_PHASE = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] state,
  output logic [7:0] state_freq,
  output logic [7:0] state_amp,
  output logic [7:0] state_phase,
  output logic       cfg_update,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GET_CMD,
    GET_DATA,
    GET_CHK
  } fsm_t;

  fsm_t            fsm, fsm_nx;
  logic [TO_W-1:0] to_cnt, to_nx, to_inc;
  logic [7:0]      cmd, cmd_nx;
  logic [7:0]      data, data_nx;
  logic            accept, reject;
  logic            legal, timeout;

  assign to_inc = to_cnt + 1'b1;

  // Fires on the cycle the counter would reach TIMEOUT-1; a byte overrides it.
  assign timeout = (fsm != IDLE) && !rx_valid &&
                   (to_inc == TO_W'(TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    case (cmd)
      8'h01:   legal = (data[7:5] == 3'd0);
      8'h02:   legal = 1'b1;
      8'h03:   legal = 1'b1;
      8'h04:   legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    fsm_nx  = fsm;
    to_nx   = (fsm == IDLE) ? '0 : to_inc;
    cmd_nx  = cmd;
    data_nx = data;
    accept  = 1'b0;
    reject  = 1'b0;
    if (rx_valid) begin
      to_nx = '0;
      unique case (fsm)
        IDLE: begin
          if (rx_data == SYNC_BYTE) fsm_nx = GET_CMD;
        end
        GET_CMD: begin
          cmd_nx = rx_data;
          fsm_nx = GET_DATA;
        end
        GET_DATA: begin
          data_nx = rx_data;
          fsm_nx  = GET_CHK;
        end
        GET_CHK: begin
          if (legal && (rx_data == (cmd ^ data))) accept = 1'b1;
          else reject = 1'b1;
          fsm_nx = IDLE;
        end
      endcase
    end else if (timeout) begin
      fsm_nx = IDLE;
      to_nx  = '0;
      reject = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= IDLE;
      to_cnt <= '0;
      cmd    <= '0;
      data   <= '0;
    end else begin
      fsm    <= fsm_nx;
      to_cnt <= to_nx;
      cmd    <= cmd_nx;
      data   <= data_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_MODE;
      state_freq  <= RST_FREQ;
      state_amp   <= RST_AMP;
      state_phase <= RST_PHASE;
      cfg_update  <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      cfg_update <= accept;
      frame_err  <= reject;
      if (reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (accept) begin
        case (cmd)
          8'h01:   state       <= data[4:0];
          8'h02:   state_freq  <= data;
          8'h03:   state_amp   <= data;
          8'h04:   state_phase <= data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Bench for usb_cmd_parser: directed frames plus random frames
// checked each cycle against a byte-queue frame model.
module tb_usb_cmd_parser;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [4:0] state;
  logic [7:0] state_freq, state_amp, state_phase, err_cnt;
  logic       cfg_update, frame_err;

  usb_cmd_parser #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .state(state),
    .state_freq(state_freq),
    .state_amp(state_amp),
    .state_phase(state_phase),
    .cfg_update(cfg_update),
    .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [4:0] m_mode;
  logic [7:0] m_freq, m_amp, m_phase, m_cnt;
  logic       m_cfg, m_err;
  logic [7:0] q[$];
  int         gap;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"}, {3'b0, state}, {3'b0, m_mode});
    chk({tag, ":freq"}, state_freq, m_freq);
    chk({tag, ":amp"}, state_amp, m_amp);
    chk({tag, ":phase"}, state_phase, m_phase);
    chk({tag, ":cfg_update"}, {7'b0, cfg_update}, {7'b0, m_cfg});
    chk({tag, ":frame_err"}, {7'b0, frame_err}, {7'b0, m_err});
    chk({tag, ":err_cnt"}, err_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_mode = 5'd0;
    m_freq = 8'd1;
    m_amp = 8'd255;
    m_phase = 8'd0;
    m_cnt = 8'd0;
    m_cfg = 1'b0;
    m_err = 1'b0;
    q.delete();
    gap = 0;
  endtask

  task automatic model_bad();
    m_err = 1'b1;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  // Whole-frame view: collect bytes from a SYNC, judge when four are held.
  task automatic model_step(input logic v, input logic [7:0] d);
    logic [7:0] c, x;
    bit ok;
    m_cfg = 1'b0;
    m_err = 1'b0;
    if (v) begin
      gap = 0;
      if (q.size() != 0 || d == 8'hA5) q.push_back(d);
      if (q.size() == 4) begin
        c = q[1];
        x = q[2];
        ok = (q[3] == (c ^ x)) &&
             ((c == 8'h01 && x < 8'h20) || (c >= 8'h02 && c <= 8'h04));
        if (ok) begin
          m_cfg = 1'b1;
          if (c == 8'h01) m_mode = x[4:0];
          else if (c == 8'h02) m_freq = x;
          else if (c == 8'h03) m_amp = x;
          else m_phase = x;
        end else begin
          model_bad();
        end
        q.delete();
      end
    end else if (q.size() != 0) begin
      gap++;
      if (gap == TMO - 1) begin
        model_bad();
        q.delete();
        gap = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input string tag);
    @(negedge clk);
    rx_valid = v;
    rx_data = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    step(1'b1, d, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, ":async"});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, ":post"});
  endtask

  int lat, pulses;

  initial begin
    model_reset();
    do_reset("reset");
    chk("reset_amp", state_amp, 8'hFF);
    chk("reset_freq", state_freq, 8'h01);

    send(8'hA5, "t1");
    send(8'h02, "t1");
    send(8'h40, "t1");
    send(8'h42, "t1");
    chk("t1_freq", state_freq, 8'h40);
    chk("t1_cfg", {7'b0, cfg_update}, 8'h01);
    idle(1, "t1");
    chk("t1_cfg_drop", {7'b0, cfg_update}, 8'h00);
    chk("t1_errcnt", err_cnt, 8'h00);

    send(8'hA5, "t2");
    send(8'h03, "t2");
    send(8'h10, "t2");
    send(8'h00, "t2");
    chk("t2_ferr", {7'b0, frame_err}, 8'h01);
    chk("t2_amp", state_amp, 8'hFF);
    chk("t2_cnt1", err_cnt, 8'h01);
    send(8'hA5, "t2");
    send(8'h07, "t2");
    send(8'h01, "t2");
    send(8'h06, "t2");
    idle(1, "t2");
    chk("t2_cnt2", err_cnt, 8'h02);

    send(8'h00, "t3");
    send(8'hFF, "t3");
    send(8'h12, "t3");
    send(8'hA5, "t3");
    send(8'h04, "t3");
    send(8'h80, "t3");
    send(8'h84, "t3");
    chk("t3_phase", state_phase, 8'h80);
    chk("t3_cnt", err_cnt, 8'h02);

    send(8'hA5, "t4");
    send(8'h01, "t4");
    lat = 0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 8'h00, "t4");
      if (frame_err === 1'b1) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    chk("t4_latency", 8'(lat), 8'd15);
    chk("t4_pulses", 8'(pulses), 8'd1);
    chk("t4_state", {3'b0, state}, 8'h00);
    send(8'hA5, "t4");
    send(8'h01, "t4");
    send(8'h03, "t4");
    send(8'h02, "t4");
    chk("t4_state3", {3'b0, state}, 8'h03);

    send(8'hA5, "t5");
    send(8'h02, "t5");
    do_reset("t5_rst");
    send(8'h02, "t5");
    send(8'h40, "t5");
    send(8'h42, "t5");
    idle(2, "t5");
    chk("t5_freq", state_freq, 8'h01);

    do_reset("rnd_rst");
    for (int f = 0; f < 200; f++) begin
      logic [7:0] c, d, k;
      if ($urandom_range(0, 3) == 0) send(8'($urandom), "rnd");
      c = 8'($urandom_range(0, 5));
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                      : 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ d);
      send(8'hA5, "rnd");
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 39) == 0) idle(20, "rnd");
        else idle($urandom_range(0, 1), "rnd");
        send(b == 0 ? c : (b == 1 ? d : k), "rnd");
      end
      idle($urandom_range(0, 2), "rnd");
    end

    for (int f = 0; f < 300; f++) begin
      logic [7:0] c, d;
      c = 8'($urandom_range(1, 4));
      d = 8'($urandom);
      send(8'hA5, "t6");
      send(c, "t6");
      send(d, "t6");
      send(c ^ d ^ 8'h5A, "t6");
    end
    chk("t6_sat", err_cnt, 8'hFF);
    send(8'hA5, "t6");
    send(8'h01, "t6");
    send(8'hE0, "t6");
    send(8'hE1, "t6");
    chk("t6_ferr", {7'b0, frame_err}, 8'h01);
    chk("t6_sat2", err_cnt, 8'hFF);
    idle(2, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
